// File: rtl/npu_mem_pkg.sv
// Shared types and default configuration for the NPU weight/image RAM arbiter.
package npu_mem_pkg;

   localparam int unsigned DEF_ADDR_W       = 15;
   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_MAX_BURST    = 16;
   localparam int unsigned DEF_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {IDLE, HOST, NPU} arb_state_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_NPU} owner_t;

   function automatic owner_t state_owner(arb_state_t st);
      case (st)
         HOST:    return OWN_HOST;
         NPU:     return OWN_NPU;
         default: return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/npu_mem_burst_ctr.sv
// Beats-per-grant counter; terminal flags the beat that brings the count to MAX_BURST.
module npu_mem_burst_ctr #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic terminal
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Combinational on the incrementing beat so the burst closes on that same edge.
   assign terminal = inc && (count_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/npu_mem_arbiter.sv
// Burst arbiter sharing one single-port RAM between a host loader (write) and the NPU (read).
// Define NPU_MEM_ARB_STATS_EN to add beat and promotion statistics counters.
module npu_mem_arbiter
   import npu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_last,
   output logic              host_gnt,
   input  logic              npu_req,
   input  logic [ADDR_W-1:0] npu_addr,
   input  logic              npu_last,
   output logic              npu_gnt,
   output logic              npu_rvalid,
   output logic [DATA_W-1:0] npu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_rdata,
`ifdef NPU_MEM_ARB_STATS_EN
   output logic [31:0]       stat_host_beats,
   output logic [31:0]       stat_npu_beats,
   output logic [15:0]       stat_promotions,
`endif
   output logic              busy
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t          state_q, state_d;
   owner_t              owner;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                npu_rvalid_q;
   logic                beat_ok;
   logic                burst_term;
   logic                burst_end;
   logic                host_starved;

   assign owner        = state_owner(state_q);
   assign host_gnt     = (owner == OWN_HOST) && host_req;
   assign npu_gnt      = (owner == OWN_NPU) && npu_req;
   assign beat_ok      = host_gnt || npu_gnt;
   assign burst_end    = (host_gnt && host_last) || (npu_gnt && npu_last) || burst_term;
   assign host_starved = (starve_q >= STARVE_W'(STARVE_LIMIT));

   assign busy       = (state_q != IDLE);
   assign npu_rvalid = npu_rvalid_q;
   assign npu_rdata  = ram_rdata;

   npu_mem_burst_ctr #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_ctr (
      .clk      (clk),
      .reset    (reset),
      .clr      (burst_end),
      .inc      (beat_ok),
      .terminal (burst_term)
   );

   // An owner that withdraws its request keeps the bus; only a burst end returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (npu_req && !(host_req && host_starved)) begin
               state_d = NPU;
            end else if (host_req) begin
               state_d = HOST;
            end
         end
         HOST, NPU: begin
            if (burst_end) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wren  = 1'b0;
      case (owner)
         OWN_HOST: begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            ram_wren  = host_req;
         end
         OWN_NPU: ram_addr = npu_addr;
         default: ;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (host_gnt) begin
         starve_d = '0;
      end else if (host_req && !host_starved) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         npu_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         npu_rvalid_q <= npu_gnt;
      end
   end

`ifdef NPU_MEM_ARB_STATS_EN
   logic [31:0] stat_host_q, stat_npu_q;
   logic [15:0] stat_promo_q;
   logic        promote;

   // Counts only decisions the host would have lost without the starvation promotion.
   assign promote = (state_q == IDLE) && host_req && npu_req && host_starved;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_host_q  <= '0;
         stat_npu_q   <= '0;
         stat_promo_q <= '0;
      end else begin
         if (host_gnt) stat_host_q  <= stat_host_q + 32'd1;
         if (npu_gnt)  stat_npu_q   <= stat_npu_q + 32'd1;
         if (promote)  stat_promo_q <= stat_promo_q + 16'd1;
      end
   end

   assign stat_host_beats = stat_host_q;
   assign stat_npu_beats  = stat_npu_q;
   assign stat_promotions = stat_promo_q;
`endif

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Scoreboard bench for npu_mem_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_npu_mem_arbiter;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              host_req, host_last, host_gnt;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              npu_req, npu_last, npu_gnt, npu_rvalid;
   logic [ADDR_W-1:0] npu_addr;
   logic [DATA_W-1:0] npu_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic              ram_wren, busy;
`ifdef NPU_MEM_ARB_STATS_EN
   logic [31:0]       stat_host_beats, stat_npu_beats;
   logic [15:0]       stat_promotions;
`endif

   logic              pl_we;
   logic [7:0]        pl_addr;
   logic [DATA_W-1:0] pl_data;
   logic [DATA_W-1:0] mem [256];

   always #5 clk = ~clk;

   npu_mem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .host_req   (host_req),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_last  (host_last),
      .host_gnt   (host_gnt),
      .npu_req    (npu_req),
      .npu_addr   (npu_addr),
      .npu_last   (npu_last),
      .npu_gnt    (npu_gnt),
      .npu_rvalid (npu_rvalid),
      .npu_rdata  (npu_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wren   (ram_wren),
      .ram_rdata  (ram_rdata),
`ifdef NPU_MEM_ARB_STATS_EN
      .stat_host_beats (stat_host_beats),
      .stat_npu_beats  (stat_npu_beats),
      .stat_promotions (stat_promotions),
`endif
      .busy       (busy)
   );

   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_wren) begin
         mem[ram_addr[7:0]] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr[7:0]];
   end

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   int                n_cmp = 0;
   int                n_err = 0;
   string             tname;
   logic [DATA_W-1:0] shadow [256];
   wr_t               exp_wr [$];
   logic [DATA_W-1:0] exp_rd [$];

   int                h_start, h_tot, h_blen, h_gap_at, h_gap_len, h_idx, h_pushed;
   logic [ADDR_W-1:0] h_base;
   logic [DATA_W-1:0] h_dbase;
   int                n_start, n_tot, n_blen, n_idx;
   logic [ADDR_W-1:0] n_base;
   int                rst_at;

   int                h_first, h_last, h_cnt, n_first, n_last, n_cnt, wren_cnt, rv_first;
   bit                bz [64];
   bit                wr_h [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_cfg(input int start, input int tot, input int blen,
                           input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] dbase,
                           input int gap_at, input int gap_len);
      h_start = start; h_tot = tot; h_blen = blen; h_base = base; h_dbase = dbase;
      h_gap_at = gap_at; h_gap_len = gap_len; h_idx = 0; h_pushed = -1;
   endtask

   task automatic npu_cfg(input int start, input int tot, input int blen,
                          input logic [ADDR_W-1:0] base);
      n_start = start; n_tot = tot; n_blen = blen; n_base = base; n_idx = 0;
   endtask

   // Drive both request streams cycle by cycle; sample #1 after the driving negedge.
   task automatic run(input int ncyc);
      int   gap_left;
      logic h_on, n_on;
      wr_t  w;
      gap_left = h_gap_len;
      h_first = -1; h_last = -1; h_cnt = 0;
      n_first = -1; n_last = -1; n_cnt = 0;
      wren_cnt = 0; rv_first = -1;
      for (int c = 0; c < ncyc; c++) begin
         reset = (c == rst_at);
         h_on = (c >= h_start) && (h_idx < h_tot);
         if (h_on && h_idx == h_gap_at && gap_left > 0) begin
            h_on = 1'b0;
            gap_left--;
         end
         host_req   = h_on;
         host_addr  = h_on ? h_base + ADDR_W'(h_idx) : '0;
         host_wdata = h_on ? h_dbase + DATA_W'(h_idx) : '0;
         host_last  = h_on && ((h_idx + 1 == h_tot) ||
                               (h_blen != 0 && (h_idx + 1) % h_blen == 0));
         if (h_on && h_idx != h_pushed) begin
            exp_wr.push_back({host_addr, host_wdata});
            shadow[host_addr[7:0]] = host_wdata;
            h_pushed = h_idx;
         end
         n_on     = (c >= n_start) && (n_idx < n_tot);
         npu_req  = n_on;
         npu_addr = n_on ? n_base + ADDR_W'(n_idx) : '0;
         npu_last = n_on && ((n_idx + 1 == n_tot) ||
                             (n_blen != 0 && (n_idx + 1) % n_blen == 0));
         #1;
         bz[c]   = busy;
         wr_h[c] = ram_wren;
         if (ram_wren) begin
            wren_cnt++;
            check({tname, ":wr_expected"}, 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               check({tname, ":wr_addr"}, 32'(ram_addr), 32'(w.addr));
               check({tname, ":wr_data"}, 32'(ram_wdata), 32'(w.data));
            end
         end
         if (npu_rvalid) begin
            if (rv_first < 0) rv_first = c;
            check({tname, ":rd_expected"}, 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
               check({tname, ":rd_data"}, 32'(npu_rdata), 32'(exp_rd.pop_front()));
            end
         end
         if (host_gnt) begin
            if (h_first < 0) h_first = c;
            h_last = c;
            h_cnt++;
            h_idx++;
         end
         if (npu_gnt) begin
            if (n_first < 0) n_first = c;
            n_last = c;
            n_cnt++;
            exp_rd.push_back(shadow[npu_addr[7:0]]);
            n_idx++;
         end
         @(posedge clk);
         if (c == rst_at) begin
            h_tot = h_idx;
            n_tot = n_idx;
            exp_wr.delete();
            exp_rd.delete();
         end
         @(negedge clk);
      end
      reset = 1'b0;
      check({tname, ":wrq_left"}, exp_wr.size(), 0);
      check({tname, ":rdq_left"}, exp_rd.size(), 0);
   endtask

   initial begin
      reset = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0; rst_at = -1;
      host_req = 1'b0; host_addr = '0; host_wdata = '0; host_last = 1'b0;
      npu_req = 1'b0; npu_addr = '0; npu_last = 1'b0;
      host_cfg(0, 0, 0, '0, '0, -1, 0);
      npu_cfg(0, 0, 0, '0);
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         pl_we     = 1'b1;
         pl_addr   = 8'(i);
         pl_data   = (i == 5) ? 8'h5C : (8'(i) ^ 8'h3C);
         shadow[i] = pl_data;
         @(negedge clk);
      end
      pl_we = 1'b0;
      reset = 1'b0;
      #1;
      tname = "reset";
      check("reset:busy", 32'(busy), 0);
      check("reset:host_gnt", 32'(host_gnt), 0);
      check("reset:npu_gnt", 32'(npu_gnt), 0);
      check("reset:ram_wren", 32'(ram_wren), 0);
      check("reset:npu_rvalid", 32'(npu_rvalid), 0);
      check("reset:ram_addr", 32'(ram_addr), 0);
      check("reset:ram_wdata", 32'(ram_wdata), 0);
      check("reset:rdata_pass", 32'(npu_rdata), 32'(ram_rdata));
      @(negedge clk);

      tname = "host_only";
      host_cfg(0, 4, 4, 15'h0000, 8'hA0, -1, 0);
      npu_cfg(0, 0, 0, '0);
      run(8);
      check("host_only:first_gnt", h_first, 1);
      check("host_only:last_gnt", h_last, 4);
      check("host_only:wren_cnt", wren_cnt, 4);
      check("host_only:busy_c1", 32'(bz[1]), 1);
      check("host_only:busy_c5", 32'(bz[5]), 0);

      tname = "npu_read";
      host_cfg(0, 0, 0, '0, '0, -1, 0);
      npu_cfg(0, 1, 0, 15'h0005);
      run(5);
      check("npu_read:first_gnt", n_first, 1);
      check("npu_read:rvalid_cycle", rv_first, 2);
      check("npu_read:wren_cnt", wren_cnt, 0);

      tname = "starve16";
      host_cfg(0, 2, 2, 15'h0020, 8'h40, -1, 0);
      npu_cfg(0, 32, 16, 15'h0080);
      run(40);
      check("starve16:npu_first", n_first, 1);
      check("starve16:host_first", h_first, 18);
      check("starve16:host_last", h_last, 19);
      check("starve16:npu_last", n_last, 36);
      check("starve16:npu_cnt", n_cnt, 32);
      check("starve16:idle_c17", 32'(bz[17]), 0);

      tname = "starve4";
      host_cfg(0, 2, 1, 15'h0028, 8'h50, -1, 0);
      npu_cfg(0, 12, 4, 15'h00A0);
      run(22);
      check("starve4:host_first", h_first, 11);
      check("starve4:host_last", h_last, 18);
      check("starve4:npu_last", n_last, 16);
      check("starve4:npu_cnt", n_cnt, 12);

      tname = "maxburst";
      host_cfg(0, 0, 0, '0, '0, -1, 0);
      npu_cfg(0, 20, 0, 15'h00C0);
      run(24);
      check("maxburst:npu_first", n_first, 1);
      check("maxburst:idle_c17", 32'(bz[17]), 0);
      check("maxburst:busy_c16", 32'(bz[16]), 1);
      check("maxburst:npu_last", n_last, 21);
      check("maxburst:npu_cnt", n_cnt, 20);

      tname = "withdraw";
      host_cfg(0, 6, 6, 15'h0030, 8'h70, 2, 3);
      npu_cfg(3, 1, 0, 15'h0009);
      run(14);
      check("withdraw:host_first", h_first, 1);
      check("withdraw:host_last", h_last, 9);
      check("withdraw:busy_gap", 32'(bz[4]), 1);
      check("withdraw:wren_gap", 32'(wr_h[4]), 0);
      check("withdraw:wren_cnt", wren_cnt, 6);
      check("withdraw:npu_first", n_first, 11);

      tname = "reset_mid";
      host_cfg(0, 8, 8, 15'h0040, 8'h90, -1, 0);
      npu_cfg(0, 0, 0, '0);
      rst_at = 3;
      run(6);
      rst_at = -1;
      check("reset_mid:host_cnt", h_cnt, 3);
      check("reset_mid:busy_c2", 32'(bz[2]), 1);
      check("reset_mid:busy_after", 32'(bz[4]), 0);
      check("reset_mid:wren_after", 32'(wr_h[4]), 0);
`ifdef NPU_MEM_ARB_STATS_EN
      check("reset_mid:stat_host", stat_host_beats, 0);
      check("reset_mid:stat_npu", stat_npu_beats, 0);
      check("reset_mid:stat_promo", 32'(stat_promotions), 0);
`endif

      tname = "post_reset";
      host_cfg(0, 0, 0, '0, '0, -1, 0);
      npu_cfg(0, 16, 0, 15'h00E0);
      run(20);
      check("post_reset:npu_first", n_first, 1);
      check("post_reset:npu_last", n_last, 16);
      check("post_reset:npu_cnt", n_cnt, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/npu_mem_arbiter.md
Name: npu_mem_arbiter

Overview:
- Shares one single-port weight/image RAM between two requesters.
  - Host load path: write-only; an upstream loader supplies addresses and data.
  - NPU compute engine: read-only.
- Grants whole bursts.
- Default priority goes to the NPU; an anti-starvation counter promotes a waiting host.
- Sits between the loader / compute engine and the RAM macro, and drives the macro's addr, data and wren pins.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, RAM word width.
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (≥2).
- STARVE_LIMIT, 8, consecutive cycles a pending host request may lose before it gets priority (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- host_req  in  1  host beat pending
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write data
- host_last  in  1  final beat of host burst
- host_gnt  out  1  host beat accepted this cycle (host_req & host_gnt)
- npu_req  in  1  NPU read beat pending
- npu_addr  in  ADDR_W  NPU read address
- npu_last  in  1  final beat of NPU burst
- npu_gnt  out  1  NPU beat accepted this cycle
- npu_rvalid  out  1  npu_rdata valid
- npu_rdata  out  DATA_W  read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, HOST, NPU.
- Registered: state, beat_cnt (clog2(MAX_BURST+1) bits), starve_cnt, npu_rvalid.
- Reset values:
  - State IDLE.
  - Counters 0.
  - host_gnt = npu_gnt = ram_wren = npu_rvalid = busy = 0.
  - ram_addr and ram_wdata = 0.
  - npu_rdata passes ram_rdata.
- IDLE decision, next edge:
  - Go to NPU if npu_req && !(host_req && starve_cnt >= STARVE_LIMIT).
  - Else go to HOST if host_req.
  - Else stay in IDLE.
  - No grants are issued while in IDLE, so the first beat is accepted one cycle after the request.
- Grants are combinational from state:
  - host_gnt = (state==HOST) & host_req.
  - npu_gnt = (state==NPU) & npu_req.
- RAM mux (combinational):
  - In HOST: ram_addr = host_addr, ram_wdata = host_wdata, ram_wren = host_req.
  - In NPU: ram_addr = npu_addr, ram_wren = 0.
  - In IDLE: ram_addr and ram_wdata are 0 and ram_wren = 0.
- npu_rvalid <= npu_gnt. Read data arrives the cycle after the accepted beat.
- beat_cnt:
  - Increments on each accepted beat.
  - Clears on entry to IDLE.
- Burst end:
  - Occurs on an accepted beat with last=1, or when that beat makes beat_cnt == MAX_BURST.
  - Next state is IDLE, giving one dead cycle for re-arbitration.
- Requester withdrawal: if the owner drops req mid-burst, hold ownership (no grant issued) until req returns. No timeout.
- starve_cnt:
  - Increments each cycle host_req=1 and host_gnt=0, saturating at STARVE_LIMIT.
  - Clears when a host beat is accepted.
- Simultaneous requests in IDLE:
  - NPU wins unless starve_cnt ≥ STARVE_LIMIT; then HOST wins.
  - After a promoted host burst completes, starve_cnt is 0 and NPU priority resumes.
- No pre-emption: a burst is never interrupted before last or MAX_BURST.
- Reset mid-burst: state forced to IDLE and counters cleared. A pending npu_rvalid is dropped the following cycle, with no spurious write.

Optional Feature:
- Macro: NPU_MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_host_beats[31:0], stat_npu_beats[31:0] and stat_promotions[15:0].
  - Accepted-beat counters and a count of IDLE decisions won by starvation promotion.
  - All counters wrap, and all clear on reset.
- Undefined: these ports and registers are absent, and the remaining behaviour is identical.

Decomposition:
- Package npu_mem_pkg:
  - arb_state_t enum {IDLE, HOST, NPU}.
  - owner_t.
  - Default constants for ADDR_W, DATA_W, MAX_BURST and STARVE_LIMIT.
- Sub-module npu_mem_burst_ctr: beat counter with clear, increment and terminal flag (== MAX_BURST); instantiated once.
- Starvation logic stays inline.

Test Plan:
- Host-only writes: host_req for 4 beats with addr 0..3, data 0xA0..0xA3, last on beat 3.
  - Required: IDLE→HOST after 1 cycle.
  - Required: ram_wren for 4 cycles with matching addr/data.
  - Required: back to IDLE, busy=0.
- NPU read latency: npu_req at addr 0x0005, last=1, RAM preloaded with 0x5C.
  - Required: npu_gnt in cycle 1.
  - Required: npu_rvalid=1 with npu_rdata=0x5C in cycle 2.
  - Required: ram_wren stays 0.
- Simultaneous requests, starve_cnt=0: NPU wins.
  - Required: host stalls and starve_cnt counts up.
  - With NPU bursting 16 beats repeatedly, the host is granted after starve_cnt reaches 8 at the next IDLE decision.
- MAX_BURST cut: NPU holds req for 20 beats with no last.
  - Required: 16 beats granted, then 1 IDLE cycle, then re-granted for 4 beats.
- Owner withdrawal: host drops req for 3 cycles mid-burst, then resumes.
  - Required: state stays HOST, no grants to either side, ram_wren=0 during the gap.
- Reset mid-burst: reset asserted on host beat 2 of 8.
  - Required: next cycle state IDLE, ram_wren=0, all counters 0.
  - With NPU_MEM_ARB_STATS_EN defined: stat_host_beats=0.
